biriscv_fetch_queue: RTL
========================

Name: biriscv_fetch_queue

Overview:
Next-generation instruction fetch unit for biRISC-V. It pipelines multiple outstanding I-cache reads and buffers responses in a parametrised instruction queue. Stale responses are discarded after a redirect using a drop counter, and fetch halts on a faulting line. It sits between the next-PC/branch-predictor logic and the decode stage, replacing the single-entry skid buffer scheme.

Parameters:
DEPTH, 4, instruction-queue entries (power of two, 2..16); each entry holds a 64-bit fetch line plus metadata.
MAX_OUTSTANDING, 2, maximum I-cache reads in flight (power of two, 1..DEPTH).
SUPPORT_MMU, 1, 1 = drive icache_priv_o from the branch privilege; 0 = tie icache_priv_o to PRIV_MACHINE.

Ports:
clk_i  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
branch_request_i  in  1  redirect fetch
branch_pc_i  in  32  redirect target
branch_priv_i  in  2  redirect privilege
fetch_invalidate_i  in  1  request I-cache flush
next_pc_f_i  in  32  predicted next PC for pc_f_o
next_taken_f_i  in  2  prediction bits for current pc_f_o
icache_accept_i  in  1  I-cache accepts read/flush
icache_valid_i  in  1  response valid (in-order)
icache_error_i  in  1  bus error on response
icache_page_fault_i  in  1  page fault on response
icache_inst_i  in  64  response line
icache_rd_o  out  1  read request
icache_flush_o  out  1  flush request
icache_pc_o  out  32  {pc_f[31:3],3'b0}
icache_priv_o  out  2  fetch privilege
pc_f_o  out  32  current fetch PC
pc_accept_o  out  1  pc_f advanced this cycle
fetch_valid_o  out  1  queue head valid
fetch_accept_i  in  1  decode accepts head
fetch_instr_o  out  64  head line
fetch_pc_o  out  32  head PC, aligned to 8 bytes
fetch_pred_branch_o  out  2  head prediction bits
fetch_fault_fetch_o  out  1  head bus error
fetch_fault_page_o  out  1  head page fault
queue_level_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset values: all outputs 0, except icache_priv_o = PRIV_MACHINE. Also active_q=0, pc_f=0, outstanding=0, drop=0, flush_pend=0.
- Issue condition: icache_rd_o = active_q & !branch_request_i & !flush_pend & (outstanding < MAX_OUTSTANDING) & (outstanding + level < DEPTH).
  - The credit rule guarantees the queue never overflows.
- Issue handshake: an issue occurs when icache_rd_o & icache_accept_i.
  - pc_f <= next_pc_f_i and pc_accept_o=1.
  - {pc_f, next_taken_f_i} is pushed into the tag FIFO (MAX_OUTSTANDING deep).
  - outstanding increments.
- Response: on icache_valid_i, outstanding decrements and the tag FIFO pops.
  - If drop>0: discard the response and decrement drop.
  - Otherwise: enqueue {page_fault, error, pred, pc, inst}.
  - Issue and response in the same cycle leave outstanding unchanged.
- Latency: a response appears on fetch_valid_o the cycle after icache_valid_i.
- Redirect (branch_request_i):
  - pc_f <= branch_pc_i, priv <= branch_priv_i, active_q <= 1; the queue is flushed (level=0).
  - drop <= outstanding - icache_valid_i, so same-cycle responses are discarded.
  - Issue is suppressed that cycle; the first read to the target goes out the following cycle.
  - Branch has priority over dequeue and enqueue in the same cycle.
- Fault: enqueueing an entry with error or page_fault clears active_q. No further issue occurs until the next redirect. Later in-flight responses are still enqueued.
- Flush: fetch_invalidate_i sets flush_pend. icache_flush_o = flush_pend, held until icache_accept_i.
  - Reads are blocked while flush_pend is set.
  - fetch_invalidate_i and branch in the same cycle: both take effect.
- Dequeue: fetch_valid_o & fetch_accept_i pops the head. Full queue plus simultaneous pop and push is legal.
- Queue pointers wrap modulo DEPTH. level is DEPTH when full, 0 when empty.
- Reset mid-operation: all state clears asynchronously. Responses arriving after reset deassertion with outstanding=0 are ignored.

Optional Feature:
BIRISCV_FETCH_BYPASS_EN:
- Defined: when the queue is empty and drop=0, a response is presented combinationally on fetch_* in the same cycle as icache_valid_i.
  - If fetch_accept_i is high, the line is not written to the queue.
  - Zero-cycle latency.
- Undefined: all responses pass through the queue (1-cycle latency).

Decomposition:
- Shared package biriscv_defs:
  - PRIV_MACHINE/PRIV_SUPER/PRIV_USER constants.
  - Fetch entry field widths and the entry bit layout (100 bits: page_fault, error, pred[1:0], pc[31:0], inst[63:0]).
- One sub-module, biriscv_fetch_fifo: generic synchronous FIFO (WIDTH, DEPTH, push/pop/flush, level). It is instantiated twice: the tag FIFO and the instruction queue.

Test Plan:
- Streaming, DEPTH=4, MAX_OUTSTANDING=2:
  - Stimulus: branch to 0x8000_0000, 1-cycle I-cache, fetch_accept_i=1.
  - Required: fetch_pc_o sequence 0x8000_0000, 0x8000_0008, 0x8000_0010; one line per cycle after fill; outstanding never exceeds 2.
- Backpressure:
  - Stimulus: fetch_accept_i=0 for 10 cycles.
  - Required: queue_level_o saturates at 4, icache_rd_o drops to 0, no line is lost; releasing fetch_accept_i drains 4 lines in order.
- Redirect with 2 in flight:
  - Stimulus: branch to 0x0000_1000 while outstanding=2.
  - Required: the two old responses are dropped; the first fetch_pc_o after the redirect is 0x0000_1000.
- Same-cycle branch and response:
  - Stimulus: branch_request_i and icache_valid_i in the same cycle, outstanding=1.
  - Required: drop=0, the response is discarded, the queue is empty next cycle.
- Fault:
  - Stimulus: icache_page_fault_i on the line at 0x2000.
  - Required: the entry appears with fetch_fault_page_o=1; no further icache_rd_o until the next branch.
- Flush:
  - Stimulus: fetch_invalidate_i pulse with icache_accept_i held low 3 cycles.
  - Required: icache_flush_o high for 4 cycles, icache_rd_o=0 throughout.

Source files
------------

// File: rtl/biriscv_defs.sv
// biriscv_defs: privilege encodings and fetch-entry layout shared by the fetch unit
package biriscv_defs;
  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;
  localparam int INST_W  = 64;
  localparam int PC_W    = 32;
  localparam int PRED_W  = 2;
  localparam int ENTRY_W = 2 + PRED_W + PC_W + INST_W;
  typedef struct packed {
    logic              page_fault;
    logic              error;
    logic [PRED_W-1:0] pred;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/biriscv_fetch_fifo.sv
// biriscv_fetch_fifo: synchronous FIFO with flush and occupancy level
// Ports: clk_i/rst_n clock and async active-low reset; flush_i empties the FIFO;
// push_i/data_i write; pop_i/data_o/valid_o read the head; level_o is occupancy (DEPTH when full).
module biriscv_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic pop_ok;
  assign pop_ok  = pop_i & (level_q != '0);
  assign data_o  = mem_q[rd_q];
  assign valid_o = level_q != '0;
  assign level_o = level_q;
  always_comb begin
    wr_d    = flush_i ? '0 : !push_i ? wr_q : (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
    rd_d    = flush_i ? '0 : !pop_ok ? rd_q : (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
    level_d = flush_i ? '0 : level_q + LW'(push_i) - LW'(pop_ok);
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  always_ff @(posedge clk_i)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/biriscv_fetch_queue.sv
// biriscv_fetch_queue: pipelined I-cache fetch with instruction queue, redirect drop counter and fault halt
// Ports: branch_* redirect fetch; fetch_invalidate_i requests an I-cache flush; next_pc_f_i/next_taken_f_i
// come from the predictor for pc_f_o; icache_* is the in-order I-cache read/flush interface;
// fetch_* presents the queue head to decode; queue_level_o is queue occupancy.
// Optional macro BIRISCV_FETCH_BYPASS_EN: present a response combinationally when the queue is empty.
module biriscv_fetch_queue
  import biriscv_defs::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int SUPPORT_MMU     = 1,
  localparam int LW = $clog2(DEPTH) + 1,
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          branch_request_i,
  input  logic [31:0]   branch_pc_i,
  input  logic [1:0]    branch_priv_i,
  input  logic          fetch_invalidate_i,
  input  logic [31:0]   next_pc_f_i,
  input  logic [1:0]    next_taken_f_i,
  input  logic          icache_accept_i,
  input  logic          icache_valid_i,
  input  logic          icache_error_i,
  input  logic          icache_page_fault_i,
  input  logic [63:0]   icache_inst_i,
  output logic          icache_rd_o,
  output logic          icache_flush_o,
  output logic [31:0]   icache_pc_o,
  output logic [1:0]    icache_priv_o,
  output logic [31:0]   pc_f_o,
  output logic          pc_accept_o,
  output logic          fetch_valid_o,
  input  logic          fetch_accept_i,
  output logic [63:0]   fetch_instr_o,
  output logic [31:0]   fetch_pc_o,
  output logic [1:0]    fetch_pred_branch_o,
  output logic          fetch_fault_fetch_o,
  output logic          fetch_fault_page_o,
  output logic [LW-1:0] queue_level_o
);
  logic active_q, active_d, flush_pend_q, flush_pend_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [1:0] priv_q, priv_d;
  logic [OW-1:0] drop_q, drop_d, outstanding;
  logic [28:0] tag_pc;
  logic [1:0] tag_pred;
  logic tag_valid, q_valid, q_push, bypass, issue, resp, accept_line;
  logic [LW-1:0] q_level;
  logic [LW:0] used;
  fetch_entry_t resp_ent, q_data, head;
  // The tag FIFO level is the outstanding-read count; it is never flushed so
  // dropped responses still retire their tags in order.
  biriscv_fetch_fifo #(.WIDTH(31), .DEPTH(MAX_OUTSTANDING)) u_tag (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(1'b0),
    .push_i(issue), .data_i({pc_f_q[31:3], next_taken_f_i}),
    .pop_i(resp), .data_o({tag_pc, tag_pred}), .valid_o(tag_valid), .level_o(outstanding)
  );
  biriscv_fetch_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_queue (
    .clk_i(clk_i), .rst_n(rst_n), .flush_i(branch_request_i),
    .push_i(q_push), .data_i(resp_ent),
    .pop_i(fetch_accept_i), .data_o(q_data), .valid_o(q_valid), .level_o(q_level)
  );
  // A response with no read in flight (e.g. just after reset) is ignored.
  assign resp        = icache_valid_i & tag_valid;
  assign accept_line = resp & (drop_q == '0) & ~branch_request_i;
  assign resp_ent    = {icache_page_fault_i, icache_error_i, tag_pred, tag_pc, 3'b000, icache_inst_i};
`ifdef BIRISCV_FETCH_BYPASS_EN
  assign bypass = accept_line & (q_level == '0);
  assign q_push = accept_line & ~(bypass & fetch_accept_i);
`else
  assign bypass = 1'b0;
  assign q_push = accept_line;
`endif
  // Counting in-flight reads against free queue slots means every response has a slot.
  assign used        = (LW + 1)'(outstanding) + (LW + 1)'(q_level);
  assign icache_rd_o = active_q & ~branch_request_i & ~flush_pend_q &
                       (outstanding < OW'(MAX_OUTSTANDING)) & (used < (LW + 1)'(DEPTH));
  assign issue       = icache_rd_o & icache_accept_i;
  assign head        = bypass ? resp_ent : q_valid ? q_data : '0;
  always_comb begin
    pc_f_d       = branch_request_i ? branch_pc_i : issue ? next_pc_f_i : pc_f_q;
    priv_d       = branch_request_i ? branch_priv_i : priv_q;
    active_d     = branch_request_i | (active_q & ~(accept_line & (icache_error_i | icache_page_fault_i)));
    drop_d       = branch_request_i ? outstanding - OW'(resp) : drop_q - OW'(resp & (drop_q != '0));
    flush_pend_d = fetch_invalidate_i | (flush_pend_q & ~icache_accept_i);
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      active_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      pc_f_q       <= '0;
      priv_q       <= PRIV_MACHINE;
      drop_q       <= '0;
    end else begin
      active_q     <= active_d;
      flush_pend_q <= flush_pend_d;
      pc_f_q       <= pc_f_d;
      priv_q       <= priv_d;
      drop_q       <= drop_d;
    end
  assign icache_flush_o      = flush_pend_q;
  assign icache_pc_o         = {pc_f_q[31:3], 3'b000};
  assign icache_priv_o       = SUPPORT_MMU != 0 ? priv_q : PRIV_MACHINE;
  assign pc_f_o              = pc_f_q;
  assign pc_accept_o         = issue;
  assign fetch_valid_o       = q_valid | bypass;
  assign fetch_instr_o       = head.inst;
  assign fetch_pc_o          = head.pc;
  assign fetch_pred_branch_o = head.pred;
  assign fetch_fault_fetch_o = head.error;
  assign fetch_fault_page_o  = head.page_fault;
  assign queue_level_o       = q_level;
endmodule
